// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with writeback bypass and per-register pending scoreboard
// Reads are combinational; issue marks a destination pending, writeback stores data and clears it.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREAD*ADDR_W-1:0]   rd_addr,
   output logic [NREAD*DATA_W-1:0]   rd_data,
   output logic [NREAD-1:0]          rd_busy,
   input  logic                      wb_en,
   input  logic [ADDR_W-1:0]         wb_addr,
   input  logic [DATA_W-1:0]         wb_data,
   input  logic                      iss_en,
   input  logic [ADDR_W-1:0]         iss_addr,
   output logic                      iss_ready,
   input  logic                      flush,
   output logic [ADDR_W:0]           pend_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   logic wb_live;
   logic wb_store;
   logic iss_set;
   logic inc, dec;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Gating with rst keeps the bypass path quiet while reset holds the outputs at zero.
   assign wb_live  = wb_en && rst;
   assign wb_store = wb_live && !is_zero(wb_addr);

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NREAD; k++) begin
         if (is_zero(rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data[k*DATA_W +: DATA_W] = '0;
         end else if (wb_store && (wb_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data[k*DATA_W +: DATA_W] = wb_data;
         end else begin
            rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
         end
         rd_busy[k] = pend_q[rd_addr[k*ADDR_W +: ADDR_W]] &&
                      !(wb_live && (wb_addr == rd_addr[k*ADDR_W +: ADDR_W]));
      end
   end

   assign iss_ready = !pend_q[iss_addr] || (wb_live && (wb_addr == iss_addr));
   assign iss_set   = iss_en && iss_ready && !flush && !is_zero(iss_addr);

   // The count moves only on real 0->1 / 1->0 transitions so it always equals the popcount.
   assign inc = iss_set && !pend_q[iss_addr];
   assign dec = wb_en && pend_q[wb_addr] && !(iss_set && (iss_addr == wb_addr));

   always_comb begin
      mem_d = mem_q;
      if (wb_store) begin
         mem_d[wb_addr] = wb_data;
      end
   end

   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (flush) begin
         pend_d = '0;
         cnt_d  = '0;
      end else begin
         if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
         end
         if (iss_set) begin
            pend_d[iss_addr] = 1'b1;
         end
         cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
// Directed literal checks plus randomized traffic compared against an array-based model.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        iss_ready;
   logic        flush;
   logic [5:0]  pend_cnt;

   int checks = 0;
   int errors = 0;
   bit done = 0;

   logic [31:0] m_mem [32];
   bit          m_pend [32];

   regfile_sb dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .flush(flush), .pend_cnt(pend_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 0;
      end
   endtask

   function automatic bit model_ready();
      return !m_pend[iss_addr] || (wb_en && wb_addr == iss_addr);
   endfunction

   task automatic model_step();
      bit acc;
      if (!rst) return;
      acc = iss_en && !flush && model_ready();
      if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
         if (wb_en) m_pend[wb_addr] = 0;
         if (acc && iss_addr != 0) m_pend[iss_addr] = 1;
      end
   endtask

   task automatic compare_all();
      logic [4:0]  a;
      logic [31:0] ed;
      bit          eb;
      int          cnt;
      for (int k = 0; k < 2; k++) begin
         a  = rd_addr[k*5 +: 5];
         eb = rst && m_pend[a] && !(wb_en && wb_addr == a);
         if (!rst || a == 0) ed = '0;
         else if (wb_en && wb_addr == a) ed = wb_data;
         else ed = m_mem[a];
         chk($sformatf("rd_data%0d a=%0d", k, a), rd_data[k*32 +: 32], ed);
         chk($sformatf("rd_busy%0d a=%0d", k, a), {31'b0, rd_busy[k]}, {31'b0, eb});
      end
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += m_pend[i];
      chk("iss_ready", {31'b0, iss_ready}, {31'b0, (!rst) || model_ready()});
      chk("pend_cnt", {26'b0, pend_cnt}, cnt);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!done) compare_all();
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      wb_en = 0; iss_en = 0; flush = 0;
   endtask

   task automatic do_reset_mid();
      #1;
      rst = 0;
      model_reset();
   endtask

   initial begin
      rst = 0; rd_addr = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
      iss_en = 0; iss_addr = '0; flush = 0;
      model_reset();
      #12;
      chk("reset pend_cnt", {26'b0, pend_cnt}, 32'd0);
      chk("reset iss_ready", {31'b0, iss_ready}, 32'd1);
      chk("reset rd_data", rd_data[31:0], 32'd0);
      rst = 1;
      cyc();

      // write r5, then read on both ports; r0 reads zero
      wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      cyc(); idle();
      rd_addr = {5'd5, 5'd5}; #1;
      chk("r5 port0", rd_data[31:0], 32'hDEADBEEF);
      chk("r5 port1", rd_data[63:32], 32'hDEADBEEF);
      rd_addr = {5'd5, 5'd0}; #1;
      chk("r0 port0", rd_data[31:0], 32'd0);

      // same-cycle bypass
      wb_en = 1; wb_addr = 7; wb_data = 32'h12345678; rd_addr = {5'd0, 5'd7}; #1;
      chk("bypass r7", rd_data[31:0], 32'h12345678);
      cyc(); idle();

      // issue r3, stall re-issue, writeback clears
      iss_en = 1; iss_addr = 3; cyc(); idle();
      rd_addr = {5'd0, 5'd3}; #1;
      chk("r3 busy", {31'b0, rd_busy[0]}, 32'd1);
      chk("cnt after r3", {26'b0, pend_cnt}, 32'd1);
      iss_en = 1; iss_addr = 3; #1;
      chk("r3 waw stall", {31'b0, iss_ready}, 32'd0);
      cyc(); idle();
      chk("cnt after stall", {26'b0, pend_cnt}, 32'd1);
      wb_en = 1; wb_addr = 3; wb_data = 32'h33; #1;
      chk("r3 busy wb", {31'b0, rd_busy[0]}, 32'd0);
      cyc(); idle();
      chk("cnt after wb r3", {26'b0, pend_cnt}, 32'd0);

      // issue and writeback r9 in the same cycle while pending: set wins
      iss_en = 1; iss_addr = 9; cyc(); idle();
      iss_en = 1; iss_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99; #1;
      chk("r9 ready", {31'b0, iss_ready}, 32'd1);
      cyc(); idle();
      rd_addr = {5'd0, 5'd9}; #1;
      chk("r9 busy", {31'b0, rd_busy[0]}, 32'd1);
      chk("cnt r9", {26'b0, pend_cnt}, 32'd1);
      wb_en = 1; wb_addr = 9; cyc(); idle();

      // flush wins over a same-cycle issue
      iss_en = 1; iss_addr = 1; cyc();
      iss_addr = 2; cyc();
      iss_addr = 4; cyc(); idle();
      chk("cnt three", {26'b0, pend_cnt}, 32'd3);
      flush = 1; iss_en = 1; iss_addr = 6; cyc(); idle();
      chk("cnt flush", {26'b0, pend_cnt}, 32'd0);
      rd_addr = {5'd1, 5'd6}; #1;
      chk("r6 not busy", {31'b0, rd_busy[0]}, 32'd0);
      chk("r1 not busy", {31'b0, rd_busy[1]}, 32'd0);

      // r0 is never written or pending
      wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
      rd_addr = {5'd0, 5'd0}; #1;
      chk("r0 bypass", rd_data[31:0], 32'd0);
      chk("r0 busy", {31'b0, rd_busy[0]}, 32'd0);
      cyc(); idle();
      chk("r0 cnt", {26'b0, pend_cnt}, 32'd0);
      chk("r0 read", rd_data[31:0], 32'd0);

      // asynchronous reset mid-sequence
      iss_en = 1; iss_addr = 5; cyc(); idle();
      chk("cnt r5", {26'b0, pend_cnt}, 32'd1);
      wb_en = 1; wb_addr = 5; wb_data = 32'hCAFE; rd_addr = {5'd5, 5'd5};
      do_reset_mid(); #1;
      chk("rst cnt", {26'b0, pend_cnt}, 32'd0);
      chk("rst rd_data", rd_data[31:0], 32'd0);
      chk("rst busy", {30'b0, rd_busy}, 32'd0);
      chk("rst ready", {31'b0, iss_ready}, 32'd1);
      cyc(); idle(); rst = 1;
      cyc();
      chk("r5 cleared", rd_data[31:0], 32'd0);

      // randomized traffic, checked every negedge by the compare process
      for (int n = 0; n < 3000; n++) begin
         rd_addr  = ($urandom % 2) ? 10'($urandom) : {2'b0, 3'($urandom), 2'b0, 3'($urandom)};
         wb_en    = 1'($urandom);
         wb_addr  = ($urandom % 2) ? 5'($urandom) : {2'b0, 3'($urandom)};
         wb_data  = $urandom;
         iss_en   = 1'($urandom);
         iss_addr = ($urandom % 2) ? 5'($urandom) : {2'b0, 3'($urandom)};
         flush    = ($urandom % 25) == 0;
         if (n == 1500) begin
            do_reset_mid();
            cyc();
            rst = 1;
         end else begin
            cyc();
         end
      end
      idle();
      cyc();
      done = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
